// File: rtl/riscv_opfwd.sv
// ---------------------------------------------------------------------------
// riscv_opfwd
//
// Operand-forwarding and capture stage at the ID/EX boundary. For each source
// operand it selects the youngest in-flight result (EX, MEM, WB, DWB) or the
// register-file read data, then registers both operands into EX. Load-use
// hazards stall ID until the load data reaches WB, and the number of stall
// cycles charged to load-use is counted for performance monitoring.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   id_valid_i                    ID holds a valid instruction
//   id_rs1_i, id_rs2_i            source register indices
//   id_rs1_use_i, id_rs2_use_i    instruction actually reads rs1/rs2
//   rf_rs1_i, rf_rs2_i            register-file read data
//   <stage>_valid_i               stage holds a result-writing instruction
//   <stage>_rd_i, <stage>_r_i     destination index and result per stage
//   ex_load_i, mem_load_i         EX/MEM instruction is a load (no data yet)
//   ex_stall_i                    EX cannot accept; registered outputs hold
//   ex_opa_o, ex_opb_o            registered operands
//   ex_valid_o                    registered operands valid
//   id_stall_o                    combinational ID hold request
//   lu_stall_cnt_o                saturating load-use stall-cycle counter
// ---------------------------------------------------------------------------
module riscv_opfwd #(
    parameter int unsigned MXLEN = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic [MXLEN-1:0] rf_rs1_i,
    input  logic [MXLEN-1:0] rf_rs2_i,

    input  logic             ex_valid_i,
    input  logic             mem_valid_i,
    input  logic             wb_valid_i,
    input  logic             dwb_valid_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       mem_rd_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [4:0]       dwb_rd_i,
    input  logic [MXLEN-1:0] ex_r_i,
    input  logic [MXLEN-1:0] mem_r_i,
    input  logic [MXLEN-1:0] wb_r_i,
    input  logic [MXLEN-1:0] dwb_r_i,
    input  logic             ex_load_i,
    input  logic             mem_load_i,

    input  logic             ex_stall_i,

    output logic [MXLEN-1:0] ex_opa_o,
    output logic [MXLEN-1:0] ex_opb_o,
    output logic             ex_valid_o,
    output logic             id_stall_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o
);

    typedef enum logic {
        RUN,
        LDWAIT
    } state_e;

    // Stage bundles, index 0 = EX (youngest) ... 3 = DWB (oldest).
    logic [3:0]            st_valid;
    logic [3:0][4:0]       st_rd;
    logic [3:0][MXLEN-1:0] st_r;
    logic [3:0]            st_fwd_ok;
    logic [3:0]            match1;
    logic [3:0]            match2;

    logic [MXLEN-1:0] opa_sel;
    logic [MXLEN-1:0] opb_sel;
    logic             hazard;

    logic [MXLEN-1:0] opa_d, opa_q;
    logic [MXLEN-1:0] opb_d, opb_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    state_e           state_d, state_q;

    assign st_valid  = {dwb_valid_i, wb_valid_i, mem_valid_i, ex_valid_i};
    assign st_rd     = {dwb_rd_i, wb_rd_i, mem_rd_i, ex_rd_i};
    assign st_r      = {dwb_r_i, wb_r_i, mem_r_i, ex_r_i};
    // A load in EX/MEM has no data yet, so its match is not a forwarding
    // source; selection falls through to the next older stage instead.
    assign st_fwd_ok = {1'b1, 1'b1, ~mem_load_i, ~ex_load_i};

    // Per-stage index match; x0 never matches anything.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int s = 0; s < 4; s++) begin
            match1[s] = st_valid[s] & (st_rd[s] == id_rs1_i) & (id_rs1_i != 5'd0);
            match2[s] = st_valid[s] & (st_rd[s] == id_rs2_i) & (id_rs2_i != 5'd0);
        end
    end

    // Walk from oldest to youngest so the youngest eligible stage wins.
    // x0 reads as zero whatever the register file returns.
    always_comb begin
        opa_sel = rf_rs1_i;
        opb_sel = rf_rs2_i;
        for (int s = 3; s >= 0; s--) begin
            if (st_fwd_ok[s] && match1[s]) begin
                opa_sel = st_r[s];
            end
            if (st_fwd_ok[s] && match2[s]) begin
                opb_sel = st_r[s];
            end
        end
        if (id_rs1_i == 5'd0) begin
            opa_sel = '0;
        end
        if (id_rs2_i == 5'd0) begin
            opb_sel = '0;
        end
    end

    // Load-use: a used operand matches a load still in EX or MEM.
    assign hazard = id_valid_i &
                    ((id_rs1_use_i & ((match1[0] & ex_load_i) | (match1[1] & mem_load_i))) |
                     (id_rs2_use_i & ((match2[0] & ex_load_i) | (match2[1] & mem_load_i))));

    assign id_stall_o = hazard;

    // Capture, bubble insertion and stall counting. When EX is stalled the
    // stall cycle is attributed to EX, so the load-use counter stays put.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!ex_stall_i) begin
            if (hazard || !id_valid_i) begin
                valid_d = 1'b0;
            end else begin
                opa_d   = opa_sel;
                opb_d   = opb_sel;
                valid_d = 1'b1;
            end
            if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Tracks whether ID is currently waiting on load data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hazard && !ex_stall_i) begin
                    state_d = LDWAIT;
                end
            end
            LDWAIT: begin
                if (!hazard) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opa_q   <= '0;
            opb_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ex_opa_o       = opa_q;
    assign ex_opb_o       = opb_q;
    assign ex_valid_o     = valid_q;
    assign lu_stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_opfwd.sv
// ---------------------------------------------------------------------------
// tb_riscv_opfwd
//
// Self-checking bench for riscv_opfwd. Each applied stimulus is run through a
// behavioural reference model; the expected registered outputs are queued and
// a monitor compares them against the DUT one cycle later. id_stall_o is
// compared combinationally as stimulus is applied.
// ---------------------------------------------------------------------------
module tb_riscv_opfwd;

    localparam int MXLEN = 32;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic            id_valid;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            use1;
        logic            use2;
        logic [31:0]     rf1;
        logic [31:0]     rf2;
        logic [3:0]      sv;
        logic [3:0][4:0] srd;
        logic [3:0][31:0] sr;
        logic            exl;
        logic            meml;
        logic            exs;
    } stim_t;

    typedef struct packed {
        logic             valid;
        logic [31:0]      opa;
        logic [31:0]      opb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i;
    logic id_rs1_use_i, id_rs2_use_i;
    logic [MXLEN-1:0] rf_rs1_i, rf_rs2_i;
    logic ex_valid_i, mem_valid_i, wb_valid_i, dwb_valid_i;
    logic [4:0] ex_rd_i, mem_rd_i, wb_rd_i, dwb_rd_i;
    logic [MXLEN-1:0] ex_r_i, mem_r_i, wb_r_i, dwb_r_i;
    logic ex_load_i, mem_load_i, ex_stall_i;
    logic [MXLEN-1:0] ex_opa_o, ex_opb_o;
    logic ex_valid_o, id_stall_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;

    int checks = 0;
    int errors = 0;

    exp_t sbq[$];

    // Reference-model state
    logic [31:0] m_opa, m_opb;
    logic        m_valid;
    int          m_cnt;

    always #5 clk_i = ~clk_i;

    riscv_opfwd #(.MXLEN(MXLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
        .rf_rs1_i(rf_rs1_i), .rf_rs2_i(rf_rs2_i),
        .ex_valid_i(ex_valid_i), .mem_valid_i(mem_valid_i),
        .wb_valid_i(wb_valid_i), .dwb_valid_i(dwb_valid_i),
        .ex_rd_i(ex_rd_i), .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i), .dwb_rd_i(dwb_rd_i),
        .ex_r_i(ex_r_i), .mem_r_i(mem_r_i), .wb_r_i(wb_r_i), .dwb_r_i(dwb_r_i),
        .ex_load_i(ex_load_i), .mem_load_i(mem_load_i), .ex_stall_i(ex_stall_i),
        .ex_opa_o(ex_opa_o), .ex_opb_o(ex_opb_o), .ex_valid_o(ex_valid_o),
        .id_stall_o(id_stall_o), .lu_stall_cnt_o(lu_stall_cnt_o)
    );

    // Youngest producer of rs whose data exists; x0 is always zero.
    function automatic logic [31:0] refOperand(input stim_t s, input logic [4:0] rs,
                                               input logic [31:0] rf);
        logic noData;
        if (rs == 5'd0) return 32'd0;
        for (int k = 0; k < 4; k++) begin
            noData = (k == 0 && s.exl) || (k == 1 && s.meml);
            if (s.sv[k] && s.srd[k] == rs && !noData) return s.sr[k];
        end
        return rf;
    endfunction

    // A used, non-zero source whose producer is a load still in EX or MEM.
    function automatic logic refHazard(input stim_t s);
        logic [4:0] rs;
        logic       used;
        logic       isLoad;
        if (!s.id_valid) return 1'b0;
        for (int n = 0; n < 2; n++) begin
            rs   = (n == 0) ? s.rs1 : s.rs2;
            used = (n == 0) ? s.use1 : s.use2;
            for (int k = 0; k < 2; k++) begin
                isLoad = (k == 0) ? s.exl : s.meml;
                if (used && rs != 5'd0 && s.sv[k] && s.srd[k] == rs && isLoad) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic stim_t blankStim();
        stim_t s;
        s = '0;
        s.id_valid = 1'b1;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        id_valid_i   = s.id_valid;
        id_rs1_i     = s.rs1;
        id_rs2_i     = s.rs2;
        id_rs1_use_i = s.use1;
        id_rs2_use_i = s.use2;
        rf_rs1_i     = s.rf1;
        rf_rs2_i     = s.rf2;
        ex_valid_i   = s.sv[0];
        mem_valid_i  = s.sv[1];
        wb_valid_i   = s.sv[2];
        dwb_valid_i  = s.sv[3];
        ex_rd_i      = s.srd[0];
        mem_rd_i     = s.srd[1];
        wb_rd_i      = s.srd[2];
        dwb_rd_i     = s.srd[3];
        ex_r_i       = s.sr[0];
        mem_r_i      = s.sr[1];
        wb_r_i       = s.sr[2];
        dwb_r_i      = s.sr[3];
        ex_load_i    = s.exl;
        mem_load_i   = s.meml;
        ex_stall_i   = s.exs;
    endtask

    // Drive one cycle of stimulus, check the stall request, advance the
    // model and queue what EX should show after the next rising edge.
    task automatic applyStimulus(input stim_t s);
        logic h;
        exp_t e;
        @(negedge clk_i);
        driveInputs(s);
        #1;
        h = refHazard(s);
        checkOutput("id_stall", {31'd0, id_stall_o}, {31'd0, h});
        if (!s.exs) begin
            if (h || !s.id_valid) begin
                m_valid = 1'b0;
            end else begin
                m_opa   = refOperand(s, s.rs1, s.rf1);
                m_opb   = refOperand(s, s.rs2, s.rf2);
                m_valid = 1'b1;
            end
            if (h && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        end
        e.valid = m_valid;
        e.opa   = m_opa;
        e.opb   = m_opb;
        e.cnt   = m_cnt[CNT_W-1:0];
        sbq.push_back(e);
    endtask

    // Asynchronous reset at an arbitrary point in the cycle; outputs must
    // clear without waiting for a clock edge.
    task automatic doReset();
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_opa", ex_opa_o, 32'd0);
        checkOutput("rst_opb", ex_opb_o, 32'd0);
        checkOutput("rst_valid", {31'd0, ex_valid_o}, 32'd0);
        checkOutput("rst_cnt", {30'd0, lu_stall_cnt_o}, 32'd0);
        sbq.delete();
        m_opa   = '0;
        m_opb   = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
        driveInputs('0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Directed constant check, taken just after the capturing edge.
    task automatic checkAfterEdge(input string name, input logic [31:0] act_sel,
                                  input logic [31:0] exp);
        checkOutput(name, act_sel, exp);
    endtask

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("sb_valid", {31'd0, ex_valid_o}, {31'd0, e.valid});
                checkOutput("sb_opa", ex_opa_o, e.opa);
                checkOutput("sb_opb", ex_opb_o, e.opb);
                checkOutput("sb_cnt", {30'd0, lu_stall_cnt_o}, {30'd0, e.cnt});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        rst_ni = 1'b0;
        driveInputs('0);
        m_opa = '0; m_opb = '0; m_valid = 1'b0; m_cnt = 0;
        #12;
        doReset();

        // EX result beats the older WB result for the same register
        s = blankStim();
        s.rs1 = 5'd5; s.use1 = 1'b1;
        s.sv[0] = 1'b1; s.srd[0] = 5'd5; s.sr[0] = 32'h11;
        s.sv[2] = 1'b1; s.srd[2] = 5'd5; s.sr[2] = 32'h22;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_ex_fwd_opa", ex_opa_o, 32'h11);
        checkAfterEdge("dir_ex_fwd_valid", {31'd0, ex_valid_o}, 32'd1);

        // x0 is never forwarded and never read from the register file
        s = blankStim();
        s.rs1 = 5'd0; s.use1 = 1'b1; s.rf1 = 32'hDEAD;
        s.sv[0] = 1'b1; s.srd[0] = 5'd0; s.sr[0] = 32'hFFFF_FFFF;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_x0_opa", ex_opa_o, 32'd0);

        // Load-use: load in EX, then MEM, then data arrives from WB
        doReset();
        s = blankStim();
        s.rs2 = 5'd7; s.use2 = 1'b1;
        s.sv[0] = 1'b1; s.srd[0] = 5'd7; s.exl = 1'b1;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_lu_bubble1", {31'd0, ex_valid_o}, 32'd0);
        s = blankStim();
        s.rs2 = 5'd7; s.use2 = 1'b1;
        s.sv[1] = 1'b1; s.srd[1] = 5'd7; s.meml = 1'b1;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_lu_bubble2", {31'd0, ex_valid_o}, 32'd0);
        s = blankStim();
        s.rs2 = 5'd7; s.use2 = 1'b1; s.rf2 = 32'h0BAD;
        s.sv[2] = 1'b1; s.srd[2] = 5'd7; s.sr[2] = 32'hCAFE;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_lu_opb", ex_opb_o, 32'hCAFE);
        checkAfterEdge("dir_lu_cnt", {30'd0, lu_stall_cnt_o}, 32'd2);

        // DWB bypass, then fallback to the register file
        s = blankStim();
        s.rs1 = 5'd9; s.use1 = 1'b1; s.rf1 = 32'd0;
        s.sv[3] = 1'b1; s.srd[3] = 5'd9; s.sr[3] = 32'h1234;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_dwb_opa", ex_opa_o, 32'h1234);
        s.sv[3] = 1'b0; s.rf1 = 32'h5555;
        applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_dwb_rf_opa", ex_opa_o, 32'h5555);

        // Hazard while EX is stalled: everything holds, counter unchanged
        doReset();
        s = blankStim();
        s.rs1 = 5'd3; s.use1 = 1'b1;
        s.sv[0] = 1'b1; s.srd[0] = 5'd3; s.sr[0] = 32'h77;
        applyStimulus(s);
        s = blankStim();
        s.rs1 = 5'd7; s.use1 = 1'b1; s.exs = 1'b1;
        s.sv[0] = 1'b1; s.srd[0] = 5'd7; s.exl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            @(posedge clk_i); #2;
            checkAfterEdge("dir_exstall_opa", ex_opa_o, 32'h77);
            checkAfterEdge("dir_exstall_valid", {31'd0, ex_valid_o}, 32'd1);
            checkAfterEdge("dir_exstall_cnt", {30'd0, lu_stall_cnt_o}, 32'd0);
        end

        // Counter saturates at all-ones, then reset lands mid-stall
        doReset();
        s.exs = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(s);
        @(posedge clk_i); #2;
        checkAfterEdge("dir_sat_cnt", {30'd0, lu_stall_cnt_o}, 32'd3);
        applyStimulus(s);
        #3;
        doReset();

        // Randomized traffic with a biased, small register set to force matches
        for (int i = 0; i < 2000; i++) begin
            s = '0;
            s.id_valid = ($urandom_range(0, 9) != 0);
            s.rs1  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            s.rs2  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            s.use1 = ($urandom_range(0, 4) != 0);
            s.use2 = ($urandom_range(0, 4) != 0);
            s.rf1  = $urandom;
            s.rf2  = $urandom;
            for (int k = 0; k < 4; k++) begin
                s.sv[k]  = ($urandom_range(0, 3) != 0);
                s.srd[k] = 5'($urandom_range(0, 4));
                s.sr[k]  = $urandom;
            end
            s.exl  = ($urandom_range(0, 3) == 0);
            s.meml = ($urandom_range(0, 3) == 0);
            s.exs  = ($urandom_range(0, 6) == 0);
            applyStimulus(s);
            if (i % 500 == 499) begin
                #3;
                doReset();
            end
        end

        @(posedge clk_i); #3;
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_opfwd.md
Name: riscv_opfwd

Overview:
- Operand-forwarding and capture stage at the ID/EX boundary; the consumer end of the post-write-back (DWB) bypass path.
- Per source operand, selects the youngest in-flight result (EX, MEM, WB, DWB) or falls back to register-file read data, then registers both operands into EX.
- Detects load-use hazards, stalls ID until load data reaches WB, and counts load-use stall cycles for performance monitoring.

Parameters:
- MXLEN, 32, datapath width.
- CNT_W, 32, width of load-use stall counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- id_valid_i  in  1  ID holds valid instruction
- id_rs1_i, id_rs2_i  in  5 each  source register indices
- id_rs1_use_i, id_rs2_use_i  in  1 each  instruction reads rs1/rs2
- rf_rs1_i, rf_rs2_i  in  MXLEN each  register-file read data
- ex_valid_i, mem_valid_i, wb_valid_i, dwb_valid_i  in  1 each  stage holds result-writing instruction (DWB: ~dwb bubble)
- ex_rd_i, mem_rd_i, wb_rd_i, dwb_rd_i  in  5 each  destination indices
- ex_r_i, mem_r_i, wb_r_i, dwb_r_i  in  MXLEN each  stage results
- ex_load_i, mem_load_i  in  1 each  instruction in EX/MEM is a load (result not yet available)
- ex_stall_i  in  1  EX cannot accept; hold outputs
- ex_opa_o, ex_opb_o  out  MXLEN each  registered operands
- ex_valid_o  out  1  registered operands valid
- id_stall_o  out  1  combinational; ID must hold instruction
- lu_stall_cnt_o  out  CNT_W  saturating load-use stall-cycle count

Behaviour:
- Reset values: ex_opa_o = 0, ex_opb_o = 0, ex_valid_o = 0, lu_stall_cnt_o = 0, FSM = RUN.
- Source match rule, per stage S and operand n:
  - S_valid_i & (S_rd_i == id_rsn_i) & (id_rsn_i != 0).
  - Register index x0 is never forwarded; its operand is always 0 regardless of rf data.
- Forward priority: EX > MEM > WB > DWB > RF.
  - EX and MEM matches are forwarded only when that stage's load flag is 0.
- Load-use hazard: id_valid_i & id_rsn_use_i & match in EX or MEM with the load flag set.
  - When the hazard is active, id_stall_o = 1.
  - An unused operand never causes a hazard.
- Registered update:
  - If ex_stall_i: all outputs hold.
  - Else if id_stall_o or !id_valid_i: ex_valid_o <= 0 (bubble); operands hold.
  - Else: operands <= selected values, ex_valid_o <= 1.
  - Latency ID to EX is 1 cycle.
- ex_stall_i and hazard in the same cycle:
  - id_stall_o is still asserted.
  - Outputs hold.
  - The counter does not increment (stall is attributed to EX).
- FSM:
  - RUN -> LDWAIT when id_stall_o & !ex_stall_i.
  - LDWAIT -> RUN when id_stall_o deasserts.
  - lu_stall_cnt_o increments each cycle id_stall_o & !ex_stall_i, saturating at all-ones, never wrapping.
- Typical load-use (load in EX): 2 stall cycles (load in EX, then MEM); the operand is forwarded from WB on the third cycle.
- DWB path covers a consumer that stalled while its producer left WB: data is taken from DWB, not from stale RF.
- Reset mid-stall: asynchronous; outputs, counter and FSM return to reset values immediately.

Test Plan:
- EX forward: add x5 in EX (ex_r=0x11), WB also x5 (wb_r=0x22), ID reads rs1=x5 -> next cycle ex_opa_o=0x11, ex_valid_o=1.
- x0: id_rs1=0, ex_rd=0, ex_r=0xFFFF_FFFF, rf_rs1=0xDEAD -> ex_opa_o=0.
- Load-use: lw x7 in EX, ID uses rs2=x7:
  - id_stall_o=1 for 2 cycles; ex_valid_o=0 bubbles.
  - Third cycle wb_r=0xCAFE -> ex_opb_o=0xCAFE; lu_stall_cnt_o=2.
- DWB bypass: producer x9 in DWB only (dwb_r=0x1234), rf_rs1=0 -> ex_opa_o=0x1234; with dwb_valid=0 -> ex_opa_o=rf value.
- Downstream stall: ex_stall_i=1 for 3 cycles during a load-use hazard -> ex_opa_o/ex_valid_o unchanged, counter unchanged.
- Counter saturation: CNT_W=2, 5 stall cycles -> lu_stall_cnt_o=3; assert rst_ni low mid-stall -> all outputs 0 asynchronously.
